// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers, multiply-accumulate and flush support.
// Results are computed from operands latched at acceptance and committed after a fixed latency.
module md_unit #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;

   localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic [0:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] result;

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic               div_zero;
   logic               div_ovf;
   logic [WIDTH-1:0]   safe_sb;
   logic [WIDTH-1:0]   safe_ub;
   logic [WIDTH-1:0]   squo;
   logic [WIDTH-1:0]   srem;
   logic [WIDTH-1:0]   uquo;
   logic [WIDTH-1:0]   urem;

   assign busy = (state == RUN);

   // Truncating a sign-extended product to 2*WIDTH bits gives the exact two's complement product.
   assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
   assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

   // MIN / -1 is rerouted to MIN / 1, which yields exactly the wrapped result (MIN, remainder 0).
   assign div_zero = (b_q == '0);
   assign div_ovf  = (a_q == MIN_VAL) && (b_q == ONES);
   assign safe_sb  = (div_zero || div_ovf) ? ONE : b_q;
   assign safe_ub  = div_zero ? ONE : b_q;
   assign squo     = $signed(a_q) / $signed(safe_sb);
   assign srem     = $signed(a_q) % $signed(safe_sb);
   assign uquo     = a_q / safe_ub;
   assign urem     = a_q % safe_ub;

   always_comb begin
      result = acc_q;
      case (op_q)
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_MADD:  result = acc_q + prod_s;
         OP_MADDU: result = acc_q + prod_u;
         OP_MSUB:  result = acc_q - prod_s;
         OP_MSUBU: result = acc_q - prod_u;
         OP_DIV:   result = div_zero ? {a_q, ONES} : {srem, squo};
         OP_DIVU:  result = div_zero ? {a_q, ONES} : {urem, uquo};
         default:  result = acc_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (state == IDLE) begin
         if (start && !flush) begin
            case (op)
               OP_MTHI: hi <= a;
               OP_MTLO: lo <= a;
               OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                  op_q  <= op;
                  a_q   <= a;
                  b_q   <= b;
                  acc_q <= {hi, lo};
                  cnt   <= CNT_W'(MUL_CYCLES - 1);
                  state <= RUN;
               end
               OP_DIV, OP_DIVU: begin
                  op_q  <= op;
                  a_q   <= a;
                  b_q   <= b;
                  acc_q <= {hi, lo};
                  cnt   <= CNT_W'(DIV_CYCLES - 1);
                  state <= RUN;
               end
               default: ;
            endcase
         end
      end else begin
         if (flush) begin
            state <= IDLE;
         end else if (cnt == '0) begin
            {hi, lo} <= result;
            state    <= IDLE;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule
